// File: rtl/imm_pipe.sv
// imm_pipe: pipelined RISC-V immediate generator with valid/ready handshake.
// Ports:
//   i_clk, i_rst_n           clock (rising edge) and async active-low reset
//   i_imm_flush              drop every in-flight entry and the current input
//   i_imm_valid/o_imm_ready  input handshake, i_imm_inst is the instruction
//   o_imm_valid/i_imm_ready  output handshake
//   o_imm_data, o_imm_type   extended immediate and type (0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z)
//   o_imm_unk_cnt            saturating count of accepted type-NONE instructions
module imm_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_imm_flush,
  input  logic                  i_imm_valid,
  output logic                  o_imm_ready,
  input  logic [31:0]           i_imm_inst,
  output logic                  o_imm_valid,
  input  logic                  i_imm_ready,
  output logic [DATA_WIDTH-1:0] o_imm_data,
  output logic [2:0]            o_imm_type,
  output logic [CNT_WIDTH-1:0]  o_imm_unk_cnt
);
  logic [6:0]            w_op;
  logic [2:0]            w_type;
  logic [31:0]           w_imm;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [STAGES-1:0]     w_rdy;
  logic                  w_acc;
  logic [STAGES-1:0]     r_v;
  logic [DATA_WIDTH-1:0] r_d [STAGES];
  logic [2:0]            r_t [STAGES];
  logic [CNT_WIDTH-1:0]  r_cnt;

  assign w_op = i_imm_inst[6:0];

  always_comb begin
    w_type = (w_op == 7'b1100111 || w_op == 7'b0000011 || w_op == 7'b0010011) ? 3'd1 :
             (w_op == 7'b0100011) ? 3'd2 :
             (w_op == 7'b1100011) ? 3'd3 :
             (w_op == 7'b0110111 || w_op == 7'b0010111) ? 3'd4 :
             (w_op == 7'b1101111) ? 3'd5 :
             (w_op == 7'b1110011 && i_imm_inst[14]) ? 3'd6 : 3'd0;
    w_imm  = (w_type == 3'd1) ? {{20{i_imm_inst[31]}}, i_imm_inst[31:20]} :
             (w_type == 3'd2) ? {{20{i_imm_inst[31]}}, i_imm_inst[31:25], i_imm_inst[11:7]} :
             (w_type == 3'd3) ? {{19{i_imm_inst[31]}}, i_imm_inst[31], i_imm_inst[7],
                                 i_imm_inst[30:25], i_imm_inst[11:8], 1'b0} :
             (w_type == 3'd4) ? {i_imm_inst[31:12], 12'h000} :
             (w_type == 3'd5) ? {{11{i_imm_inst[31]}}, i_imm_inst[31], i_imm_inst[19:12],
                                 i_imm_inst[20], i_imm_inst[30:21], 1'b0} :
             (w_type == 3'd6) ? {27'd0, i_imm_inst[19:15]} : 32'd0;
  end

  // Every 32-bit form is already sign-correct (zimm has a zero top bit),
  // so a single signed widening covers RV32 and RV64.
  assign w_ext = DATA_WIDTH'($signed(w_imm));

  // Stage k can move when some stage at or after it is empty or the consumer
  // takes the head; written without a ripple chain through w_rdy itself.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign w_rdy[k] = i_imm_ready || !(&r_v[STAGES-1:k]);
  end

  assign o_imm_ready   = w_rdy[0];
  assign w_acc         = i_imm_valid && w_rdy[0] && !i_imm_flush;
  assign o_imm_valid   = r_v[STAGES-1];
  assign o_imm_data    = r_d[STAGES-1];
  assign o_imm_type    = r_t[STAGES-1];
  assign o_imm_unk_cnt = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_d[s] <= '0;
        r_t[s] <= '0;
      end
    end else begin
      if (w_acc && w_type == 3'd0 && r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_rdy[0]) begin
        r_v[0] <= i_imm_valid;
        if (i_imm_valid) begin
          r_d[0] <= w_ext;
          r_t[0] <= w_type;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_rdy[s]) begin
          r_v[s] <= r_v[s-1];
          if (r_v[s-1]) begin
            r_d[s] <= r_d[s-1];
            r_t[s] <= r_t[s-1];
          end
        end
      end
      // Flush overrides every valid update above; data may keep stale values.
      if (i_imm_flush) r_v <= '0;
    end
  end
endmodule

// File: tb/tb_imm_pipe.sv
// tb_imm_pipe: table, corner-case and randomized scoreboard checks for imm_pipe.
module tb_imm_pipe;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_imm_flush;
  logic        i_imm_valid;
  logic        o_imm_ready;
  logic [31:0] i_imm_inst;
  logic        o_imm_valid;
  logic        i_imm_ready;
  logic [63:0] o_imm_data;
  logic [2:0]  o_imm_type;
  logic [1:0]  o_imm_unk_cnt;

  imm_pipe #(.DATA_WIDTH(64), .STAGES(2), .CNT_WIDTH(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_imm_flush(i_imm_flush),
    .i_imm_valid(i_imm_valid), .o_imm_ready(o_imm_ready), .i_imm_inst(i_imm_inst),
    .o_imm_valid(o_imm_valid), .i_imm_ready(i_imm_ready), .o_imm_data(o_imm_data),
    .o_imm_type(o_imm_type), .o_imm_unk_cnt(o_imm_unk_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] d;
    logic [2:0]  t;
  } vec_t;

  int           n_pass = 0;
  int           n_total = 0;
  int           n_out = 0;
  int           cnt_m = 0;
  logic [66:0]  q[$];
  vec_t         tbl[11];
  logic [31:0]  s4[4];
  logic [6:0]   ops[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference decode: arithmetic on a sign-extended 64-bit copy of the word.
  function automatic logic [66:0] ref_dec(input logic [31:0] x);
    longint s;
    s = longint'($signed(x));
    case (x[6:0])
      7'h67, 7'h03, 7'h13: return {3'd1, s >>> 20};
      7'h23: return {3'd2, ((s >>> 25) <<< 5) | longint'(x[11:7])};
      7'h63: return {3'd3, ((s >>> 31) <<< 12) | (longint'(x[7]) << 11) |
                            (longint'(x[30:25]) << 5) | (longint'(x[11:8]) << 1)};
      7'h37, 7'h17: return {3'd4, s & ~longint'(12'hFFF)};
      7'h6F: return {3'd5, ((s >>> 31) <<< 20) | (longint'(x[19:12]) << 12) |
                            (longint'(x[20]) << 11) | (longint'(x[30:21]) << 1)};
      7'h73: return x[14] ? {3'd6, longint'(x[19:15])} : 67'd0;
      default: return 67'd0;
    endcase
  endfunction

  // One cycle: drive at negedge, score the handshakes, wait for next negedge.
  task automatic tick(input logic v, input logic [31:0] x, input logic rdy,
                      input logic fl, output logic acc);
    logic [66:0] e;
    i_imm_valid = v;
    i_imm_inst  = x;
    i_imm_ready = rdy;
    i_imm_flush = fl;
    #1;
    acc = v && o_imm_ready && !fl;
    if (o_imm_valid && rdy && !fl) begin
      chk("out_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", o_imm_data, e[63:0]);
        chk("out_type", 64'(o_imm_type), 64'(e[66:64]));
        n_out++;
      end
    end
    if (fl) q.delete();
    if (acc) begin
      e = ref_dec(x);
      q.push_back(e);
      if (e[66:64] == 3'd0 && cnt_m < 3) cnt_m++;
    end
    @(negedge i_clk);
    chk("unk_cnt", 64'(o_imm_unk_cnt), 64'(cnt_m));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_imm_valid = 1'b0;
    i_imm_flush = 1'b0;
    i_imm_ready = 1'b1;
    i_imm_inst = '0;
    q.delete();
    cnt_m = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic        a;
    int          idx;
    logic [63:0] hold_d;
    logic [2:0]  hold_t;
    logic [31:0] x;
    tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    tbl[1]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4};
    tbl[2]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    tbl[3]  = '{32'h0002D073, 64'h0000000000000005, 3'd6};
    tbl[4]  = '{32'h00029073, 64'h0000000000000000, 3'd0};
    tbl[5]  = '{32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 3'd2};
    tbl[6]  = '{32'h800000EF, 64'hFFFFFFFFFFF00000, 3'd5};
    tbl[7]  = '{32'h00001017, 64'h0000000000001000, 3'd4};
    tbl[8]  = '{32'h7FF00013, 64'h00000000000007FF, 3'd1};
    tbl[9]  = '{32'h00000000, 64'h0000000000000000, 3'd0};
    tbl[10] = '{32'h0000006F, 64'h0000000000000000, 3'd5};
    s4 = '{32'h00100093, 32'h00200113, 32'hFFE00193, 32'h12345237};
    ops = '{7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};

    do_reset();
    #1;
    chk("rst_valid", 64'(o_imm_valid), 64'd0);
    chk("rst_data", o_imm_data, 64'd0);
    chk("rst_type", 64'(o_imm_type), 64'd0);
    chk("rst_cnt", 64'(o_imm_unk_cnt), 64'd0);
    chk("rst_ready", 64'(o_imm_ready), 64'd1);
    @(negedge i_clk);

    for (int i = 0; i < 11; i++) begin
      tick(1'b1, tbl[i].inst, 1'b1, 1'b0, a);
      chk("tbl_accept", 64'(a), 64'd1);
      chk("tbl_lat_early", 64'(o_imm_valid), 64'd0);
      tick(1'b0, 32'd0, 1'b1, 1'b0, a);
      chk("tbl_lat_valid", 64'(o_imm_valid), 64'd1);
      chk("tbl_data", o_imm_data, tbl[i].d);
      chk("tbl_type", 64'(o_imm_type), 64'(tbl[i].t));
    end
    tick(1'b0, 32'd0, 1'b1, 1'b0, a);
    chk("tbl_cnt", 64'(o_imm_unk_cnt), 64'd2);

    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      tick(1'b1, s4[idx], 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("stall_accepts", 64'(idx), 64'd2);
    chk("stall_ready_low", 64'(o_imm_ready), 64'd0);
    chk("stall_valid", 64'(o_imm_valid), 64'd1);
    hold_d = o_imm_data;
    hold_t = o_imm_type;
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, s4[idx], 1'b0, 1'b0, a);
      chk("stall_no_accept", 64'(a), 64'd0);
      chk("stall_hold_data", o_imm_data, hold_d);
      chk("stall_hold_type", 64'(o_imm_type), 64'(hold_t));
    end
    n_out = 0;
    for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
      tick(idx < 4, s4[idx < 4 ? idx : 0], 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("stall_delivered", 64'(n_out), 64'd4);
    chk("stall_drained", 64'(q.size()), 64'd0);

    tick(1'b1, 32'h00100093, 1'b0, 1'b0, a);
    tick(1'b1, 32'h00200093, 1'b0, 1'b0, a);
    chk("flush_pre_valid", 64'(o_imm_valid), 64'd1);
    tick(1'b1, 32'h00000000, 1'b1, 1'b1, a);
    chk("flush_valid", 64'(o_imm_valid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 32'd0, 1'b1, 1'b0, a);
      chk("flush_dropped", 64'(o_imm_valid), 64'd0);
    end

    tick(1'b1, 32'h00000000, 1'b0, 1'b0, a);
    tick(1'b1, 32'h00000000, 1'b0, 1'b0, a);
    i_imm_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_imm_valid), 64'd0);
    chk("arst_data", o_imm_data, 64'd0);
    chk("arst_type", 64'(o_imm_type), 64'd0);
    chk("arst_cnt", 64'(o_imm_unk_cnt), 64'd0);
    q.delete();
    cnt_m = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      x = $urandom;
      if ($urandom_range(7) != 0) x[6:0] = ops[$urandom_range(9)];
      tick($urandom_range(3) != 0, x, $urandom_range(3) != 0, $urandom_range(31) == 0, a);
    end
    for (int c = 0; c < 6; c++) tick(1'b0, 32'd0, 1'b1, 1'b0, a);
    chk("rand_drained", 64'(q.size()), 64'd0);

    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 32'h00000000, 1'b1, 1'b0, a);
      chk("sat_cnt", 64'(o_imm_unk_cnt), 64'(c < 3 ? c + 1 : 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got hung run expected finish");
    $fatal(1);
  end
endmodule
